offset_table_loader: RTL and testbench

- Sequencer that programs the Programmed Offset (PO) and Default Offset (DO) entries of the Address Module.
- Emits memory-mapped writes into the PO/DO write space (H memory), one per thread slot of the target thread.
- Sits on the initiator side of the offset-update write port. It is driven by a control master (debug or boot loader) that requests "program entries first..first+count-1 of thread T".
- Retries any write whose slot is cancelled.

---
 rtl/offset_table_loader_pkg.sv | 17 +
 rtl/offset_table_loader_if.sv | 37 +++
 rtl/offset_table_loader_thread_slot_counter.sv | 15 +
 rtl/offset_table_loader.sv | 157 +++++++++++++++
 tb/tb_offset_table_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/offset_table_loader_pkg.sv
// Shared types and constants for the PO/DO offset table loader.
// The PO entry field positions below apply to the default operand widths.
package offset_table_loader_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, PO, DO} state_t;

  localparam int unsigned DEF_ADDR_WIDTH    = 10;
  localparam int unsigned DEF_PO_INCR_WIDTH = 4;

  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned INCR_LSB   = DEF_ADDR_WIDTH;
  localparam int unsigned SIGN_BIT   = DEF_ADDR_WIDTH + DEF_PO_INCR_WIDTH;

  localparam logic [11:0] DEF_PO_ADDR_BASE = 12'hE00;
  localparam logic [11:0] DEF_DO_ADDR      = 12'hE04;

endpackage

// File: rtl/offset_table_loader_if.sv
// Command and offset-update write bundle between a control master and the loader.
interface offset_table_loader_if #(
  parameter int unsigned WRITE_WORD_WIDTH   = 36,
  parameter int unsigned WRITE_ADDR_WIDTH   = 12,
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned PO_INCR_WIDTH      = 4,
  parameter int unsigned PO_ADDR_WIDTH      = 2,
  parameter int unsigned THREAD_COUNT_WIDTH = 3
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [THREAD_COUNT_WIDTH-1:0] cmd_thread;
  logic [PO_ADDR_WIDTH-1:0]      cmd_first;
  logic [PO_ADDR_WIDTH:0]        cmd_count;
  logic [ADDR_WIDTH-1:0]         cmd_offset;
  logic [ADDR_WIDTH-1:0]         cmd_stride;
  logic [PO_INCR_WIDTH-1:0]      cmd_incr;
  logic                          cmd_incr_sign;
  logic                          cmd_do_en;
  logic [ADDR_WIDTH-1:0]         cmd_do_value;
  logic                          slot_cancel;
  logic                          write_valid;
  logic [WRITE_ADDR_WIDTH-1:0]   write_addr;
  logic [WRITE_WORD_WIDTH-1:0]   write_data;

  modport master (
    output cmd_valid, cmd_thread, cmd_first, cmd_count, cmd_offset, cmd_stride,
           cmd_incr, cmd_incr_sign, cmd_do_en, cmd_do_value, slot_cancel,
    input  cmd_ready, write_valid, write_addr, write_data
  );

  modport slave (
    input  cmd_valid, cmd_thread, cmd_first, cmd_count, cmd_offset, cmd_stride,
           cmd_incr, cmd_incr_sign, cmd_do_en, cmd_do_value, slot_cancel,
    output cmd_ready, write_valid, write_addr, write_data
  );
endinterface

// File: rtl/offset_table_loader_thread_slot_counter.sv
// Free-running modulo-COUNT thread slot counter with asynchronous reset.
module thread_slot_counter #(
  parameter int unsigned COUNT = 8,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          value <= '0;
    else if (value == WIDTH'(COUNT - 1)) value <= '0;
    else                                value <= value + WIDTH'(1);
  end
endmodule

// File: rtl/offset_table_loader.sv
// Sequences PO/DO offset-table writes for one thread, issuing each write in that
// thread's slot and reissuing any write whose slot is cancelled.
module offset_table_loader
  import offset_table_loader_pkg::*;
#(
  parameter int unsigned WRITE_WORD_WIDTH   = 36,
  parameter int unsigned WRITE_ADDR_WIDTH   = 12,
  parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int unsigned PO_INCR_WIDTH      = DEF_PO_INCR_WIDTH,
  parameter int unsigned PO_ENTRY_COUNT     = 4,
  parameter int unsigned PO_ADDR_WIDTH      = 2,
  parameter logic [WRITE_ADDR_WIDTH-1:0] PO_ADDR_BASE = DEF_PO_ADDR_BASE,
  parameter logic [WRITE_ADDR_WIDTH-1:0] DO_ADDR      = DEF_DO_ADDR,
  parameter int unsigned THREAD_COUNT       = 8,
  parameter int unsigned THREAD_COUNT_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  offset_table_loader_if.slave          bus,
  output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  localparam int unsigned SUM_WIDTH = PO_ADDR_WIDTH + 2;

  state_t                        state;
  logic [THREAD_COUNT_WIDTH-1:0] thread_q;
  logic [PO_ADDR_WIDTH-1:0]      first_q;
  logic [PO_ADDR_WIDTH:0]        count_q, k_q, k_next;
  logic [ADDR_WIDTH-1:0]         acc_q, stride_q, do_value_q;
  logic [PO_INCR_WIDTH-1:0]      incr_q;
  logic                          sign_q, do_en_q;
  logic [WRITE_ADDR_WIDTH-1:0]   addr_hold, cur_addr;
  logic [WRITE_WORD_WIDTH-1:0]   data_hold, cur_data, po_data;
  logic                          ready_q, done_q, error_q;
  logic                          fire, accepted, range_bad;

  thread_slot_counter #(.COUNT(THREAD_COUNT), .WIDTH(THREAD_COUNT_WIDTH)) u_slot (
    .clock (clock),
    .reset (reset),
    .value (current_thread)
  );

  always_comb begin
    fire      = ((state == PO) || (state == DO)) && (current_thread == thread_q);
    accepted  = fire && !bus.slot_cancel;
    k_next    = k_q + (PO_ADDR_WIDTH + 1)'(1);
    range_bad = (SUM_WIDTH'(first_q) + SUM_WIDTH'(count_q)) > SUM_WIDTH'(PO_ENTRY_COUNT);
    po_data   = '0;
    po_data[OFFSET_LSB +: ADDR_WIDTH]  = acc_q;
    po_data[INCR_LSB +: PO_INCR_WIDTH] = incr_q;
    po_data[SIGN_BIT]                  = sign_q;
    if (state == DO) begin
      cur_addr = DO_ADDR;
      cur_data = WRITE_WORD_WIDTH'(do_value_q);
    end else begin
      cur_addr = PO_ADDR_BASE + WRITE_ADDR_WIDTH'(first_q) + WRITE_ADDR_WIDTH'(k_q);
      cur_data = po_data;
    end
  end

  // Address/data are live during a write and otherwise replay the last issued write.
  assign bus.write_valid = fire;
  assign bus.write_addr  = fire ? cur_addr : addr_hold;
  assign bus.write_data  = fire ? cur_data : data_hold;
  assign bus.cmd_ready   = ready_q;
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign error           = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      thread_q   <= '0;
      first_q    <= '0;
      count_q    <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      stride_q   <= '0;
      do_value_q <= '0;
      incr_q     <= '0;
      sign_q     <= 1'b0;
      do_en_q    <= 1'b0;
      addr_hold  <= '0;
      data_hold  <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (fire) begin
        addr_hold <= cur_addr;
        data_hold <= cur_data;
      end
      case (state)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            thread_q   <= bus.cmd_thread;
            first_q    <= bus.cmd_first;
            count_q    <= bus.cmd_count;
            acc_q      <= bus.cmd_offset;
            stride_q   <= bus.cmd_stride;
            incr_q     <= bus.cmd_incr;
            sign_q     <= bus.cmd_incr_sign;
            do_en_q    <= bus.cmd_do_en;
            do_value_q <= bus.cmd_do_value;
            k_q        <= '0;
            ready_q    <= 1'b0;
            state      <= CHECK;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CHECK: begin
          if (range_bad) begin
            error_q <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else if (count_q == '0) begin
            if (do_en_q) state <= DO;
            else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            state <= PO;
          end
        end
        PO: begin
          if (accepted) begin
            k_q   <= k_next;
            acc_q <= acc_q + stride_q;
            if (k_next == count_q) begin
              if (do_en_q) state <= DO;
              else begin
                done_q  <= 1'b1;
                ready_q <= 1'b1;
                state   <= IDLE;
              end
            end
          end
        end
        DO: begin
          if (accepted) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_offset_table_loader.sv
// Directed bench for offset_table_loader with a write scoreboard.
module tb_offset_table_loader;
  import offset_table_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] current_thread;
  logic       busy, done, error;

  offset_table_loader_if #(
    .WRITE_WORD_WIDTH(36), .WRITE_ADDR_WIDTH(12), .ADDR_WIDTH(10),
    .PO_INCR_WIDTH(4), .PO_ADDR_WIDTH(2), .THREAD_COUNT_WIDTH(3)
  ) bus ();

  offset_table_loader dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .current_thread (current_thread),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [35:0] data;
    logic [2:0]  thread;
  } wr_t;

  wr_t         sb[$];
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, pulses = 0, accepted = 0, dones = 0;
  int unsigned last_accept_cyc = 0, last_fire_cyc = 0;
  int unsigned cmd_id = 0, last_fire_id = 0, cancel_budget = 0;
  logic [35:0] last_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every write strobe with the scoreboard head and drives slot_cancel.
  always @(negedge clock) begin
    bus.slot_cancel = 1'b0;
    if (done === 1'b1) dones++;
    if (bus.write_valid === 1'b1) begin
      pulses++;
      if (last_fire_id == cmd_id) check("spacing", 64'(cyc - last_fire_cyc), 64'd8);
      last_fire_id  = cmd_id;
      last_fire_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(sb.size()), 64'd1);
      end else begin
        check("write_addr", 64'(bus.write_addr), 64'(sb[0].addr));
        check("write_data", 64'(bus.write_data), 64'(sb[0].data));
        check("write_slot", 64'(current_thread), 64'(sb[0].thread));
        last_data = bus.write_data;
        if (cancel_budget > 0) begin
          bus.slot_cancel = 1'b1;
          cancel_budget--;
        end else begin
          void'(sb.pop_front());
          accepted++;
          last_accept_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] thread, input logic [1:0] first, input logic [2:0] count,
                       input logic [9:0] offset, input logic [9:0] stride, input logic [3:0] incr,
                       input logic sign, input logic do_en, input logic [9:0] do_value);
    logic [9:0] acc;
    wr_t        w;
    if (int'(first) + int'(count) <= 4) begin
      acc = offset;
      for (int i = 0; i < int'(count); i++) begin
        w.addr   = 12'hE00 + 12'(first) + 12'(i);
        w.data   = {21'd0, sign, incr, acc};
        w.thread = thread;
        sb.push_back(w);
        acc = acc + stride;
      end
      if (do_en) begin
        w.addr   = 12'hE04;
        w.data   = 36'(do_value);
        w.thread = thread;
        sb.push_back(w);
      end
    end
    @(negedge clock);
    cmd_id++;
    bus.cmd_thread    = thread;
    bus.cmd_first     = first;
    bus.cmd_count     = count;
    bus.cmd_offset    = offset;
    bus.cmd_stride    = stride;
    bus.cmd_incr      = incr;
    bus.cmd_incr_sign = sign;
    bus.cmd_do_en     = do_en;
    bus.cmd_do_value  = do_value;
    bus.cmd_valid     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready === 1'b1) break;
      @(negedge clock);
    end
    check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_end(output logic got_done, output logic got_err, output int unsigned at);
    logic found = 1'b0;
    got_done = 1'b0;
    got_err  = 1'b0;
    at       = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done === 1'b1 || error === 1'b1) begin
        got_done = done;
        got_err  = error;
        at       = cyc;
        found    = 1'b1;
        break;
      end
    end
    check("end_timeout", 64'(found), 64'd1);
  endtask

  logic        d, e;
  int unsigned at, base_p, base_a, base_d;

  initial begin
    bus.cmd_valid = 1'b0;  bus.cmd_thread = '0; bus.cmd_first = '0; bus.cmd_count = '0;
    bus.cmd_offset = '0;   bus.cmd_stride = '0; bus.cmd_incr = '0;  bus.cmd_incr_sign = 1'b0;
    bus.cmd_do_en = 1'b0;  bus.cmd_do_value = '0;

    #22;
    check("rst_write_valid", 64'(bus.write_valid), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_thread", 64'(current_thread), 64'd0);
    check("rst_addr", 64'(bus.write_addr), 64'd0);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    // 1: two PO entries plus DO
    base_p = pulses;
    issue(3'd3, 2'd1, 3'd2, 10'd100, 10'd16, 4'd1, 1'b0, 1'b1, 10'd50);
    wait_end(d, e, at);
    check("t1_done", 64'(d), 64'd1);
    check("t1_done_lat", 64'(at), 64'(last_accept_cyc + 1));
    check("t1_pulses", 64'(pulses - base_p), 64'd3);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: first PO write cancelled once
    base_p = pulses; base_a = accepted;
    cancel_budget = 1;
    issue(3'd3, 2'd1, 3'd2, 10'd100, 10'd16, 4'd1, 1'b0, 1'b1, 10'd50);
    wait_end(d, e, at);
    check("t2_done", 64'(d), 64'd1);
    check("t2_pulses", 64'(pulses - base_p), 64'd4);
    check("t2_accepted", 64'(accepted - base_a), 64'd3);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: out-of-range rejection
    base_p = pulses;
    issue(3'd5, 2'd3, 3'd2, 10'd7, 10'd1, 4'd0, 1'b0, 1'b1, 10'd3);
    wait_end(d, e, at);
    check("t3_error", 64'(e), 64'd1);
    check("t3_no_done", 64'(d), 64'd0);
    check("t3_ready", 64'(bus.cmd_ready), 64'd1);
    check("t3_pulses", 64'(pulses - base_p), 64'd0);

    // 4: empty commands
    base_p = pulses;
    issue(3'd2, 2'd0, 3'd0, 10'd9, 10'd1, 4'd0, 1'b0, 1'b0, 10'd0);
    wait_end(d, e, at);
    check("t4a_done", 64'(d), 64'd1);
    check("t4a_pulses", 64'(pulses - base_p), 64'd0);
    base_p = pulses;
    issue(3'd6, 2'd2, 3'd0, 10'd9, 10'd1, 4'd0, 1'b0, 1'b1, 10'd77);
    wait_end(d, e, at);
    check("t4b_done", 64'(d), 64'd1);
    check("t4b_pulses", 64'(pulses - base_p), 64'd1);

    // 5: offset wrap, then sign/incr field placement
    issue(3'd1, 2'd0, 3'd2, 10'd1020, 10'd8, 4'd0, 1'b0, 1'b0, 10'd0);
    wait_end(d, e, at);
    check("t5_wrap", 64'(last_data[9:0]), 64'd4);
    issue(3'd4, 2'd2, 3'd1, 10'd5, 10'd0, 4'd15, 1'b1, 1'b0, 10'd0);
    wait_end(d, e, at);
    check("t5_sign", 64'(last_data[14]), 64'd1);
    check("t5_incr", 64'(last_data[13:10]), 64'd15);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6: reset between the two PO writes
    base_p = pulses; base_a = accepted;
    issue(3'd3, 2'd0, 3'd2, 10'd200, 10'd3, 4'd2, 1'b0, 1'b1, 10'd9);
    for (int i = 0; i < 40; i++) begin
      if (accepted != base_a) break;
      @(negedge clock);
    end
    check("t6_first_write", 64'(accepted - base_a), 64'd1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_write_valid", 64'(bus.write_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_ready", 64'(bus.cmd_ready), 64'd0);
    check("t6_thread", 64'(current_thread), 64'd0);
    check("t6_addr", 64'(bus.write_addr), 64'd0);
    check("t6_data", 64'(bus.write_data), 64'd0);
    sb.delete();
    base_d = dones;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("t6_no_writes", 64'(pulses - base_p), 64'd1);
    check("t6_no_done", 64'(dones - base_d), 64'd0);
    check("t6_ready_after", 64'(bus.cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
